// File: rtl/pll_clken_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// pll_seq_pkg
//   Shared types and constants for the post-PLL clock-enable / reset
//   sequencer: the sequencer state encoding, the depth of the lock-flag
//   synchronizer and the width of the relock event counter.
// ----------------------------------------------------------------------------
package pll_seq_pkg;

    // Sequencer states: wait for lock, qualify it, release channels one by
    // one, then run with all channels out of reset.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    // Flops in the pll_locked clock-domain-crossing synchronizer.
    localparam int SYNC_DEPTH = 2;

    // Width of the saturating count of lock losses seen from RUN.
    localparam int RELOCK_W = 8;

endpackage : pll_seq_pkg

// File: rtl/pll_clken_sequencer_if.sv
// ----------------------------------------------------------------------------
// pll_clken_sequencer_if
//   Bundles the sequencer's functional signals.
//     pll_locked  raw PLL lock flag (asynchronous to the sequencer clock)
//     ch_div      per-channel period minus one, channel k at [k*DIV_W +: DIV_W]
//     ch_phase    per-channel initial divider count, same packing as ch_div
//     ch_en       registered one-cycle enable strobes, one per channel
//     ch_rst      registered per-channel resets, active-high
//     ready       high while the sequencer is in RUN
//     relock_cnt  saturating count of lock losses seen from RUN
//   The master modport is the environment side (drives the PLL flag and the
//   divider settings); the slave modport is the sequencer side.
// ----------------------------------------------------------------------------
interface pll_clken_sequencer_if
    import pll_seq_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DIV_W  = 8
);

    logic                      pll_locked;
    logic [NUM_CH*DIV_W-1:0]   ch_div;
    logic [NUM_CH*DIV_W-1:0]   ch_phase;
    logic [NUM_CH-1:0]         ch_en;
    logic [NUM_CH-1:0]         ch_rst;
    logic                      ready;
    logic [RELOCK_W-1:0]       relock_cnt;

    modport master (
        output pll_locked,
        output ch_div,
        output ch_phase,
        input  ch_en,
        input  ch_rst,
        input  ready,
        input  relock_cnt
    );

    modport slave (
        input  pll_locked,
        input  ch_div,
        input  ch_phase,
        output ch_en,
        output ch_rst,
        output ready,
        output relock_cnt
    );

endinterface : pll_clken_sequencer_if

// File: rtl/pll_clken_sequencer_clken_divider.sv
// ----------------------------------------------------------------------------
// clken_divider
//   One channel's clock-enable generator. Produces a registered strobe with
//   period i_div+1; i_div=0 gives a strobe that stays high.
//     i_clock  sequencer clock
//     i_reset  synchronous active-high reset
//     i_run    channel is out of reset and counting
//     i_load   channel leaves reset on this edge: preload the counter
//     i_div    period minus one
//     i_phase  initial counter value (clamped to i_div)
//     o_en     registered enable strobe
// ----------------------------------------------------------------------------
module clken_divider #(
    parameter int DIV_W = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_run,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_div,
    input  logic [DIV_W-1:0] i_phase,
    output logic             o_en
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_en;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt <= '0;
            r_en  <= 1'b0;
        end else if (i_load) begin
            // Clamp the phase so the counter always reaches i_div and wraps.
            r_cnt <= (i_phase < i_div) ? i_phase : i_div;
            r_en  <= 1'b0;
        end else if (i_run) begin
            if (r_cnt == i_div) begin
                r_cnt <= '0;
                r_en  <= 1'b1;
            end else begin
                r_cnt <= r_cnt + DIV_W'(1);
                r_en  <= 1'b0;
            end
        end else begin
            // Held in reset: the counter value is don't-care until the next load.
            r_en <= 1'b0;
        end
    end

    assign o_en = r_en;

endmodule : clken_divider

// File: rtl/pll_clken_sequencer.sv
// ----------------------------------------------------------------------------
// pll_clken_sequencer
//   Post-PLL clock-enable and reset sequencer. Qualifies the PLL lock flag,
//   releases the channel resets in a fixed staggered order, then runs one
//   clken_divider per channel. A filtered loss of lock puts every channel
//   back into reset.
//     i_clock  primary (fastest) PLL output clock
//     i_reset  synchronous active-high reset
//     bus      pll_clken_sequencer_if.slave (see the interface for signals)
// ----------------------------------------------------------------------------
module pll_clken_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int DIV_W       = 8,
    parameter int HOLD_CYCLES = 1024,
    parameter int STAGE_GAP   = 16,
    parameter int LOSS_FILTER = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    pll_clken_sequencer_if.slave  bus
);

    localparam int HOLD_W  = $clog2(HOLD_CYCLES);
    localparam int GAP_W   = (STAGE_GAP   > 1) ? $clog2(STAGE_GAP)   : 1;
    localparam int LOSS_W  = (LOSS_FILTER > 1) ? $clog2(LOSS_FILTER) : 1;
    localparam int STAGE_W = (NUM_CH      > 1) ? $clog2(NUM_CH)      : 1;

    // ------------------------------------------------------------------
    // Lock synchronizer
    // ------------------------------------------------------------------
    logic [SYNC_DEPTH-1:0] r_sync;
    logic                  w_lk_s;

    always_ff @(posedge i_clock) begin
        // NOTE: sequential state is always assigned with <= so every flop
        // samples the pre-edge value of its neighbours; with = the chain
        // would collapse into a single flop.
        if (i_reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], bus.pll_locked};
        end
    end

    assign w_lk_s = r_sync[SYNC_DEPTH-1];

    // ------------------------------------------------------------------
    // Sequencer state and counters
    // ------------------------------------------------------------------
    seq_state_e           r_state,      w_state_nxt;
    logic [HOLD_W-1:0]    r_hold_cnt,   w_hold_cnt_nxt;
    logic [GAP_W-1:0]     r_gap_cnt,    w_gap_cnt_nxt;
    logic [STAGE_W-1:0]   r_stage,      w_stage_nxt;
    logic [LOSS_W-1:0]    r_loss_cnt,   w_loss_cnt_nxt;
    logic [NUM_CH-1:0]    r_ch_rst,     w_ch_rst_nxt;
    logic                 r_ready,      w_ready_nxt;
    logic [RELOCK_W-1:0]  r_relock_cnt, w_relock_cnt_nxt;

    logic                 w_loss;       // filtered loss of lock this edge
    logic                 w_latch;      // capture divider settings this edge
    logic [NUM_CH-1:0]    w_load;       // channel leaves reset this edge
    logic [NUM_CH-1:0]    w_run;        // channel divider may count this edge

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        w_state_nxt      = r_state;
        w_hold_cnt_nxt   = r_hold_cnt;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_stage_nxt      = r_stage;
        w_loss_cnt_nxt   = '0;
        w_ch_rst_nxt     = r_ch_rst;
        w_ready_nxt      = r_ready;
        w_relock_cnt_nxt = r_relock_cnt;
        w_loss           = 1'b0;
        w_latch          = 1'b0;
        w_load           = '0;

        // Loss filter: only armed once lock has been qualified. The count
        // clears on any synced-high cycle (through the default above).
        if ((r_state == RELEASE || r_state == RUN) && !w_lk_s) begin
            if (r_loss_cnt == LOSS_W'(LOSS_FILTER - 1)) begin
                w_loss = 1'b1;
            end else begin
                w_loss_cnt_nxt = r_loss_cnt + LOSS_W'(1);
            end
        end

        unique case (r_state)
            WAIT_LOCK: begin
                if (w_lk_s) begin
                    w_state_nxt    = HOLD;
                    w_hold_cnt_nxt = '0;
                end
            end

            HOLD: begin
                // Unfiltered: any drop during qualification restarts it.
                if (!w_lk_s) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                    w_state_nxt   = RELEASE;
                    w_gap_cnt_nxt = '0;
                    w_stage_nxt   = '0;
                    w_latch       = 1'b1;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end

            RELEASE: begin
                if (r_gap_cnt == GAP_W'(STAGE_GAP - 1)) begin
                    w_gap_cnt_nxt         = '0;
                    w_ch_rst_nxt[r_stage] = 1'b0;
                    w_load[r_stage]       = 1'b1;
                    if (r_stage == STAGE_W'(NUM_CH - 1)) begin
                        w_state_nxt = RUN;
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_stage_nxt = r_stage + STAGE_W'(1);
                    end
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
                end
            end

            RUN: begin
                // Steady state; only the loss filter can leave it.
            end

            default: begin
                w_state_nxt = WAIT_LOCK;
            end
        endcase

        // A loss overrides anything decided above, including a stage
        // release on the same edge.
        if (w_loss) begin
            w_state_nxt  = WAIT_LOCK;
            w_ch_rst_nxt = '1;
            w_ready_nxt  = 1'b0;
            w_load       = '0;
            if (r_state == RUN && r_relock_cnt != '1) begin
                w_relock_cnt_nxt = r_relock_cnt + RELOCK_W'(1);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= WAIT_LOCK;
            r_hold_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_stage      <= '0;
            r_loss_cnt   <= '0;
            r_ch_rst     <= '1;
            r_ready      <= 1'b0;
            r_relock_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_stage      <= w_stage_nxt;
            r_loss_cnt   <= w_loss_cnt_nxt;
            r_ch_rst     <= w_ch_rst_nxt;
            r_ready      <= w_ready_nxt;
            r_relock_cnt <= w_relock_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Shadow copies of the divider settings, captured once per bring-up
    // ------------------------------------------------------------------
    logic [NUM_CH*DIV_W-1:0] r_div_sh;
    logic [NUM_CH*DIV_W-1:0] r_phase_sh;

    // NOTE: these registers carry no reset on purpose: they are always
    // written on the HOLD->RELEASE edge before any divider reads them, so a
    // reset would only add fan-out on the reset net.
    always_ff @(posedge i_clock) begin
        if (w_latch) begin
            r_div_sh   <= bus.ch_div;
            r_phase_sh <= bus.ch_phase;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel dividers
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] w_en;

    // A loss must force the strobes low on the same edge the resets assert.
    assign w_run = ~r_ch_rst & ~{NUM_CH{w_loss}};

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        clken_divider #(
            .DIV_W (DIV_W)
        ) u_div (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_run   (w_run[k]),
            .i_load  (w_load[k]),
            .i_div   (r_div_sh[k*DIV_W +: DIV_W]),
            .i_phase (r_phase_sh[k*DIV_W +: DIV_W]),
            .o_en    (w_en[k])
        );
    end

    assign bus.ch_en      = w_en;
    assign bus.ch_rst     = r_ch_rst;
    assign bus.ready      = r_ready;
    assign bus.relock_cnt = r_relock_cnt;

endmodule : pll_clken_sequencer

// File: doc/pll_clken_sequencer.md
# pll_clken_sequencer

Post-PLL clock-enable and reset sequencer. It runs on the primary (fastest) PLL output clock and watches the PLL `locked` flag. After a qualified lock it releases per-channel resets in a fixed staggered order, then generates NUM_CH divided clock-enable strobes, each with its own programmable ratio and phase. Design blocks use these strobes instead of extra PLL outputs, and loss of lock sends every channel back into reset.

## Interface
Parameters:
- NUM_CH, 3: number of enable/reset channels (1..8).
- DIV_W, 8: width of the per-channel divide and phase fields.
- HOLD_CYCLES, 1024: cycles lock must stay stable before release begins (≥2).
- STAGE_GAP, 16: cycles between successive channel reset releases (≥1).
- LOSS_FILTER, 4: consecutive low cycles of synced lock that count as a loss (≥1).

Ports:
- clock  in  1  primary PLL output clock.
- reset  in  1  synchronous, active-high.
- pll_locked  in  1  raw PLL locked flag, asynchronous to clock.
- ch_div  in  NUM_CH*DIV_W  per channel, period minus one (channel k at bits [k*DIV_W +: DIV_W]).
- ch_phase  in  NUM_CH*DIV_W  per-channel initial counter value.
- ch_en  out  NUM_CH  registered one-cycle enable strobes.
- ch_rst  out  NUM_CH  registered per-channel reset, active-high.
- ready  out  1  high while in RUN.
- relock_cnt  out  8  count of losses from RUN; saturates at 255.

## Operation
- **Reset values:** ch_rst all 1, ch_en 0, ready 0, relock_cnt 0, state WAIT_LOCK, synchronizer flops 0.
- **Lock synchronizer:** pll_locked passes through a 2-flop synchronizer; its output is lk_s.
- **WAIT_LOCK:** when lk_s=1, go to HOLD with hold_cnt=0.
- **HOLD:**
  - Increment hold_cnt each cycle.
  - Any cycle with lk_s=0 returns to WAIT_LOCK. There is no filter in this state.
  - At hold_cnt=HOLD_CYCLES-1, go to RELEASE with gap_cnt=0 and stage=0. On the same edge, latch ch_div and ch_phase into shadow registers. These inputs are ignored at all other times.
- **RELEASE:**
  - gap_cnt counts 0..STAGE_GAP-1.
  - At the edge after gap_cnt=STAGE_GAP-1: clear ch_rst[stage], increment stage, and reset gap_cnt to 0.
  - After channel NUM_CH-1 is released, go to RUN and set ready=1 on that same edge.
- **Loss filter (RELEASE and RUN):**
  - A counter of consecutive lk_s=0 cycles clears whenever lk_s=1.
  - When the counter reaches LOSS_FILTER: set all ch_rst=1, ch_en=0, ready=0, and go to WAIT_LOCK.
  - relock_cnt increments (saturating) only when the loss occurs from RUN.
- **Channel divider k:**
  - On the edge where ch_rst[k] clears, load cnt_k = min(phase_k, div_k) and set ch_en[k]=0.
  - On each later edge while ch_rst[k]=0: if cnt_k==div_k, set cnt_k←0 and ch_en[k]←1; otherwise set cnt_k←cnt_k+1 and ch_en[k]←0.
  - Strobe period is div_k+1. With div_k=0 the strobe stays high continuously.
  - While ch_rst[k]=1, ch_en[k] is 0.
- **Simultaneous events:**
  - reset overrides everything.
  - A loss on the same edge as a stage release wins: that channel stays in reset.
- **Reset mid-operation:** all outputs take their reset values on the next edge, including relock_cnt.

## Timing
- Edge 0 is the first edge that samples pll_locked=1; lk_s=1 after edge 1.
- HOLD is entered at edge 2.
- ch_rst[k] falls at edge 2+HOLD_CYCLES+(k+1)*STAGE_GAP. ready rises on the same edge as ch_rst[NUM_CH-1].
- The first ch_en[k] pulse is visible after edge R_k + (div_k − min(phase_k,div_k)) + 1, where R_k is that channel's release edge.
- Loss reaction: from the first low sample of pll_locked, resets assert at edge 1+LOSS_FILTER.
- All outputs are registered and there are no combinational paths from input to output.

## Structure
- **Package `pll_seq_pkg`:**
  - State enum WAIT_LOCK/HOLD/RELEASE/RUN.
  - Synchronizer depth constant (2).
  - relock_cnt width constant (8).
- **Sub-module `clken_divider`:** one instance per channel. Inputs: run, load, div, phase. Output: en. Registered.
- The top level contains the synchronizer, the FSM, the hold/gap/loss counters, and the shadow registers.

## Test plan
All scenarios use NUM_CH=3, HOLD_CYCLES=16, STAGE_GAP=4, LOSS_FILTER=4.
- **Reset:** hold reset with pll_locked=1 → ch_rst=3'b111, ch_en=0, ready=0, relock_cnt=0 throughout.
- **Bring-up:** release reset, raise pll_locked (edge 0) → ch_rst[0] falls at edge 22, ch_rst[1] at 26, ch_rst[2] at 30; ready=1 at 30.
- **Dividers:** ch_div={0,3,3}, ch_phase={0,0,2} → ch0 strobes every cycle after its release. ch1 strobes every 4 cycles, first visible 4 edges after its release. ch2 strobes every 4 cycles, first visible 2 edges after its release.
- **Glitch filter:** in RUN, drop pll_locked for 3 cycles → no change. Drop it for 4 cycles → all ch_rst=1, ready=0, relock_cnt=1; on re-lock the full bring-up timing repeats.
- **Loss in HOLD:** drop pll_locked at hold_cnt=10 → returns to WAIT_LOCK; re-lock again requires the full 16 hold cycles; relock_cnt stays unchanged.
- **Reset mid-run:** assert reset while relock_cnt=2 and a ch_en pulse is high → next edge shows all reset values and relock_cnt=0.
